// File: rtl/sp_optimizer_param.sv
// sp_optimizer_param
// Dual-axis solar-panel tracker. Manual mode jogs the pan (H) and tilt (V)
// axes from level buttons. Auto mode hill-climbs the panel voltage by
// perturb-and-observe, with hysteresis, a settle delay and position
// saturation. Two registered servo PWM outputs follow the axis positions.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   BTN_L/BTN_R              H jog decrement/increment (level)
//   BTN_U/BTN_D              V jog increment/decrement (level)
//   BTN_C                    mode toggle on rising edge
//   V_in, V_VALID            panel-voltage sample and its one-cycle strobe
//   SERVO_H, SERVO_V         servo PWM outputs
//   POS_H, POS_V             current axis positions
//   max_V_in                 largest accepted sample since entering auto
//   direction_lr/_ud         search direction (2'b10 up, 2'b01 down)
//   STAT                     FSM state code
//   AUTO                     high in auto mode
module sp_optimizer_param #(
  parameter int unsigned V_W        = 12,
  parameter int unsigned POS_W      = 8,
  parameter int unsigned STEP       = 4,
  parameter int unsigned HYST       = 16,
  parameter int unsigned SETTLE_CYC = 1000000,
  parameter int unsigned MAN_DIV    = 500000,
  parameter int unsigned PWM_PERIOD = 2000000,
  parameter int unsigned PWM_MIN    = 100000,
  parameter int unsigned PWM_STEP   = 392
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_L,
  input  logic             BTN_R,
  input  logic             BTN_U,
  input  logic             BTN_D,
  input  logic             BTN_C,
  input  logic [V_W-1:0]   V_in,
  input  logic             V_VALID,
  output logic             SERVO_H,
  output logic             SERVO_V,
  output logic [POS_W-1:0] POS_H,
  output logic [POS_W-1:0] POS_V,
  output logic [V_W-1:0]   max_V_in,
  output logic [1:0]       direction_lr,
  output logic [1:0]       direction_ud,
  output logic [2:0]       STAT,
  output logic             AUTO
);

  localparam int unsigned DIV_W = $clog2(MAN_DIV + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CNT_W = $clog2(PWM_PERIOD + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MAN_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  localparam logic [POS_W-1:0] POS_MAX = '1;
  localparam logic [POS_W-1:0] POS_MID = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [1:0]       DIR_INC = 2'b10;
  localparam logic [1:0]       DIR_DEC = 2'b01;
  localparam logic [V_W:0]     HYST_X  = (V_W+1)'(HYST);

  typedef enum logic [2:0] {
    ST_MANUAL = 3'b000,
    ST_REF    = 3'b001,
    ST_MOVE   = 3'b010,
    ST_SETTLE = 3'b011,
    ST_MEAS   = 3'b100,
    ST_DECIDE = 3'b101
  } state_e;

  state_e             state_q, state_d;
  logic               auto_q, auto_d;
  logic               btn_c_q;
  logic [POS_W-1:0]   pos_h_q, pos_h_d;
  logic [POS_W-1:0]   pos_v_q, pos_v_d;
  logic [POS_W-1:0]   prev_pos_q, prev_pos_d;
  logic [1:0]         dir_h_q, dir_h_d;
  logic [1:0]         dir_v_q, dir_v_d;
  logic               axis_q, axis_d;      // 0 = H, 1 = V
  logic [V_W-1:0]     v_ref_q, v_ref_d;
  logic [V_W-1:0]     v_new_q, v_new_d;
  logic [V_W-1:0]     max_q, max_d;
  logic [1:0]         fail_q, fail_d;
  logic               lim_q, lim_d;        // last MOVE hit a limit
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               servo_h_q, servo_v_q;

  logic               btn_c_rise;
  logic               any_btn;
  logic [POS_W-1:0]   cur_pos;
  logic [1:0]         cur_dir;
  logic [1:0]         flip_dir;
  logic [1:0]         fail_inc;
  logic [V_W:0]       v_new_x, v_ref_x;
  logic [31:0]        thr_h, thr_v;

  function automatic logic [POS_W-1:0] step_up(input logic [POS_W-1:0] p,
                                               input int unsigned n);
    logic [POS_W:0] s;
    s = {1'b0, p} + (POS_W+1)'(n);
    return s[POS_W] ? POS_MAX : s[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] step_down(input logic [POS_W-1:0] p,
                                                 input int unsigned n);
    logic [POS_W:0] nn;
    nn = (POS_W+1)'(n);
    return ({1'b0, p} < nn) ? '0 : (p - nn[POS_W-1:0]);
  endfunction

  assign btn_c_rise = BTN_C & ~btn_c_q;
  assign any_btn    = BTN_L | BTN_R | BTN_U | BTN_D;
  assign cur_pos    = axis_q ? pos_v_q : pos_h_q;
  assign cur_dir    = axis_q ? dir_v_q : dir_h_q;
  assign flip_dir   = (cur_dir == DIR_INC) ? DIR_DEC : DIR_INC;
  assign fail_inc   = fail_q + 2'd1;
  assign v_new_x    = {1'b0, v_new_q};
  assign v_ref_x    = {1'b0, v_ref_q};

  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    pos_h_d    = pos_h_q;
    pos_v_d    = pos_v_q;
    prev_pos_d = prev_pos_q;
    dir_h_d    = dir_h_q;
    dir_v_d    = dir_v_q;
    axis_d     = axis_q;
    v_ref_d    = v_ref_q;
    v_new_d    = v_new_q;
    max_d      = max_q;
    fail_d     = fail_q;
    lim_d      = lim_q;
    div_d      = '0;
    settle_d   = '0;

    if (btn_c_rise) begin
      auto_d = ~auto_q;
      if (auto_q) begin
        state_d = ST_MANUAL;
      end else begin
        state_d = ST_REF;
        max_d   = '0;
      end
    end else begin
      case (state_q)
        ST_MANUAL: begin
          if (any_btn) begin
            if (div_q == DIV_LAST) begin
              if (BTN_R && !BTN_L) pos_h_d = step_up(pos_h_q, 1);
              if (BTN_L && !BTN_R) pos_h_d = step_down(pos_h_q, 1);
              if (BTN_U && !BTN_D) pos_v_d = step_up(pos_v_q, 1);
              if (BTN_D && !BTN_U) pos_v_d = step_down(pos_v_q, 1);
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end

        ST_REF: begin
          if (V_VALID) begin
            v_ref_d = V_in;
            if (V_in > max_q) max_d = V_in;
            state_d = ST_MOVE;
          end
        end

        ST_MOVE: begin
          lim_d = 1'b0;
          if ((cur_dir == DIR_INC && cur_pos == POS_MAX) ||
              (cur_dir != DIR_INC && cur_pos == '0)) begin
            if (axis_q) dir_v_d = flip_dir;
            else        dir_h_d = flip_dir;
            fail_d  = fail_inc;
            lim_d   = 1'b1;
            state_d = ST_DECIDE;
          end else begin
            prev_pos_d = cur_pos;
            if (axis_q) pos_v_d = (cur_dir == DIR_INC) ? step_up(cur_pos, STEP)
                                                       : step_down(cur_pos, STEP);
            else        pos_h_d = (cur_dir == DIR_INC) ? step_up(cur_pos, STEP)
                                                       : step_down(cur_pos, STEP);
            state_d = ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_q == SET_LAST) state_d  = ST_MEAS;
          else                      settle_d = settle_q + 1'b1;
        end

        ST_MEAS: begin
          if (V_VALID) begin
            v_new_d = V_in;
            if (V_in > max_q) max_d = V_in;
            state_d = ST_DECIDE;
          end
        end

        ST_DECIDE: begin
          // A limit hit carries no fresh measurement, so only the fail
          // count is judged; the direction was already flipped in MOVE.
          if (lim_q) begin
            if (fail_q >= 2'd2) begin
              axis_d  = ~axis_q;
              fail_d  = '0;
              state_d = ST_REF;
            end else begin
              state_d = ST_MOVE;
            end
          end else if (v_new_x > v_ref_x + HYST_X) begin
            v_ref_d = v_new_q;
            fail_d  = '0;
            state_d = ST_MOVE;
          end else if (v_new_x + HYST_X < v_ref_x) begin
            if (axis_q) begin
              pos_v_d = prev_pos_q;
              dir_v_d = flip_dir;
            end else begin
              pos_h_d = prev_pos_q;
              dir_h_d = flip_dir;
            end
            if (fail_inc >= 2'd2) begin
              axis_d  = ~axis_q;
              fail_d  = '0;
              state_d = ST_REF;
            end else begin
              fail_d  = fail_inc;
              state_d = ST_MOVE;
            end
          end else begin
            axis_d  = ~axis_q;
            fail_d  = '0;
            state_d = ST_REF;
          end
        end

        default: state_d = ST_MANUAL;
      endcase
    end
  end

  // PWM thresholds use the live position so moves apply mid-frame.
  assign thr_h = 32'(PWM_MIN) + 32'(pos_h_q) * 32'(PWM_STEP);
  assign thr_v = 32'(PWM_MIN) + 32'(pos_v_q) * 32'(PWM_STEP);
  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_MANUAL;
      auto_q     <= 1'b0;
      btn_c_q    <= 1'b0;
      pos_h_q    <= POS_MID;
      pos_v_q    <= POS_MID;
      prev_pos_q <= POS_MID;
      dir_h_q    <= DIR_INC;
      dir_v_q    <= DIR_INC;
      axis_q     <= 1'b0;
      v_ref_q    <= '0;
      v_new_q    <= '0;
      max_q      <= '0;
      fail_q     <= '0;
      lim_q      <= 1'b0;
      div_q      <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      servo_h_q  <= 1'b0;
      servo_v_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      btn_c_q    <= BTN_C;
      pos_h_q    <= pos_h_d;
      pos_v_q    <= pos_v_d;
      prev_pos_q <= prev_pos_d;
      dir_h_q    <= dir_h_d;
      dir_v_q    <= dir_v_d;
      axis_q     <= axis_d;
      v_ref_q    <= v_ref_d;
      v_new_q    <= v_new_d;
      max_q      <= max_d;
      fail_q     <= fail_d;
      lim_q      <= lim_d;
      div_q      <= div_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      servo_h_q  <= (32'(cnt_q) < thr_h);
      servo_v_q  <= (32'(cnt_q) < thr_v);
    end
  end

  assign SERVO_H      = servo_h_q;
  assign SERVO_V      = servo_v_q;
  assign POS_H        = pos_h_q;
  assign POS_V        = pos_v_q;
  assign max_V_in     = max_q;
  assign direction_lr = dir_h_q;
  assign direction_ud = dir_v_q;
  assign STAT         = state_q;
  assign AUTO         = auto_q;

endmodule

// File: tb/tb_sp_optimizer_param.sv
// Directed bench for sp_optimizer_param with small parameters
// (POS_W=4, STEP=1, HYST=8, SETTLE_CYC=4, MAN_DIV=4, PWM_PERIOD=100,
// PWM_MIN=10, PWM_STEP=5).
module tb_sp_optimizer_param;

  logic        CLK = 1'b0;
  logic        RST, BTN_L, BTN_R, BTN_U, BTN_D, BTN_C, V_VALID;
  logic [11:0] V_in;
  logic        SERVO_H, SERVO_V;
  logic [3:0]  POS_H, POS_V;
  logic [11:0] max_V_in;
  logic [1:0]  direction_lr, direction_ud;
  logic [2:0]  STAT;
  logic        AUTO;

  int n_checks = 0;
  int n_errors = 0;
  int hi;

  sp_optimizer_param #(
    .V_W(12), .POS_W(4), .STEP(1), .HYST(8), .SETTLE_CYC(4), .MAN_DIV(4),
    .PWM_PERIOD(100), .PWM_MIN(10), .PWM_STEP(5)
  ) dut (
    .CLK(CLK), .RST(RST),
    .BTN_L(BTN_L), .BTN_R(BTN_R), .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_C(BTN_C),
    .V_in(V_in), .V_VALID(V_VALID),
    .SERVO_H(SERVO_H), .SERVO_V(SERVO_V),
    .POS_H(POS_H), .POS_V(POS_V), .max_V_in(max_V_in),
    .direction_lr(direction_lr), .direction_ud(direction_ud),
    .STAT(STAT), .AUTO(AUTO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_valid(input logic [11:0] v);
    V_in = v;
    V_VALID = 1'b1;
    tick();
    V_VALID = 1'b0;
  endtask

  task automatic count_high(input bit vert, output int n);
    n = 0;
    repeat (100) begin
      tick();
      if (vert ? SERVO_V : SERVO_H) n++;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b0; BTN_L = 0; BTN_R = 0; BTN_U = 0; BTN_D = 0; BTN_C = 0;
    V_VALID = 0; V_in = '0;
    #2;

    // 1. reset state and PWM duty at mid position
    do_reset();
    check("rst_pos_h", POS_H, 8);
    check("rst_pos_v", POS_V, 8);
    check("rst_stat", STAT, 0);
    check("rst_auto", AUTO, 0);
    check("rst_dir_lr", direction_lr, 2);
    count_high(1'b0, hi);
    check("pwm_h_mid", hi, 50);

    // 2. manual jog: step on the 4th held cycle, saturate at 15
    BTN_R = 1;
    tick(3);
    check("jog_before_div", POS_H, 8);
    tick();
    check("jog_first_step", POS_H, 9);
    tick(36);
    check("jog_saturate", POS_H, 15);
    BTN_R = 0;
    count_high(1'b0, hi);
    check("pwm_h_max", hi, 85);
    BTN_L = 1; BTN_R = 1;
    tick(8);
    check("jog_cancel", POS_H, 15);
    BTN_R = 0;
    tick(4);
    check("jog_left", POS_H, 14);
    BTN_L = 0; BTN_U = 1;
    tick(4);
    check("jog_up", POS_V, 9);
    BTN_U = 0;

    // 3. enter auto, reference, first move, settle, uphill accept
    do_reset();
    BTN_C = 1;
    tick();
    BTN_C = 0;
    check("auto_on", AUTO, 1);
    check("stat_ref", STAT, 1);
    pulse_valid(100);
    check("stat_move", STAT, 2);
    check("max_100", max_V_in, 100);
    tick();
    check("move_pos_9", POS_H, 9);
    check("stat_settle", STAT, 3);
    tick(2);
    pulse_valid(999);               // ignored while settling
    check("settle_still", STAT, 3);
    check("settle_ignore_v", max_V_in, 100);
    tick();
    check("stat_meas", STAT, 4);
    pulse_valid(120);
    check("stat_decide", STAT, 5);
    check("max_120", max_V_in, 120);
    tick(2);
    check("uphill_pos_10", POS_H, 10);

    // 4. descent: restore, flip, then switch axis on second drop
    tick(4);
    pulse_valid(200);
    tick(2);
    check("pos_11", POS_H, 11);
    tick(4);
    pulse_valid(150);
    tick();
    check("restore_pos", POS_H, 10);
    check("dir_flip", direction_lr, 1);
    check("after_drop_move", STAT, 2);
    tick();
    check("dec_move", POS_H, 9);
    tick(4);
    pulse_valid(150);
    tick();
    check("switch_ref", STAT, 1);
    check("restore2", POS_H, 10);
    check("dir_flip2", direction_lr, 2);

    // 5. hysteresis band on the V axis
    pulse_valid(200);
    tick();
    check("v_axis_move", POS_V, 9);
    check("h_untouched", POS_H, 10);
    tick(4);
    pulse_valid(205);
    tick();
    check("hyst_ref", STAT, 1);
    check("hyst_keep", POS_V, 9);
    check("max_205", max_V_in, 205);
    pulse_valid(100);
    tick();
    check("axis_back_h", POS_H, 11);
    check("v_kept", POS_V, 9);

    // 6a. reset mid-settle
    check("in_settle", STAT, 3);
    RST = 1;
    tick();
    RST = 0;
    check("rst2_pos_h", POS_H, 8);
    check("rst2_pos_v", POS_V, 8);
    check("rst2_stat", STAT, 0);
    check("rst2_auto", AUTO, 0);
    check("rst2_max", max_V_in, 0);
    check("rst2_dir_ud", direction_ud, 2);

    // 6b. mode toggle during MEAS, held BTN_C toggles once, max cleared on re-entry
    BTN_C = 1;
    tick();
    BTN_C = 0;
    pulse_valid(50);
    tick(5);
    check("meas_again", STAT, 4);
    BTN_C = 1;
    tick();
    check("exit_stat", STAT, 0);
    check("exit_auto", AUTO, 0);
    check("exit_keep_pos", POS_H, 9);
    tick(2);
    check("held_c_once", AUTO, 0);
    BTN_C = 0;
    tick();
    check("max_before_reentry", max_V_in, 50);
    BTN_C = 1;
    tick();
    BTN_C = 0;
    check("reentry_auto", AUTO, 1);
    check("reentry_max_clr", max_V_in, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
